mult_unit: RTL and testbench

- Iterative 32x32 -> 64-bit multiplier for MULT/MULTU, sitting downstream of the ID/EX operand latch and upstream of the HI/LO register file.
- Shift-add datapath; each step accumulates through a 64-bit carry-lookahead adder built from 4-bit lookahead slices.
- Start/busy/done handshake with the pipeline stall logic; the result holds on hi/lo until the next accepted start.

---
 rtl/mult_pkg.sv | 14 +
 rtl/add64_cla.sv | 44 ++++
 rtl/mult_unit.sv | 147 ++++++++++++++
 tb/tb_mult_unit.sv | 307 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the iterative MULT/MULTU unit.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2,
        DONE  = 2'd3
    } state_e;

    localparam int MULT_WIDTH = 32;
    localparam int MULT_STEPS = 32;

endpackage

// File: rtl/add64_cla.sv
// 64-bit adder: sixteen 4-bit carry-lookahead slices, carry rippling between slices.
module add64_cla (
    input  logic [63:0] a_i,
    input  logic [63:0] b_i,
    input  logic        cin_i,
    output logic [63:0] sum_o,
    output logic        cout_o
);

    logic [63:0] g;
    logic [63:0] p;
    logic [16:0] c;

    assign g    = a_i & b_i;
    assign p    = a_i ^ b_i;
    assign c[0] = cin_i;

    for (genvar s = 0; s < 16; s++) begin : g_slice
        logic [3:0] gs;
        logic [3:0] ps;
        logic [3:0] cs;
        logic       grp_g;
        logic       grp_p;

        assign gs    = g[4*s +: 4];
        assign ps    = p[4*s +: 4];
        assign cs[0] = c[s];
        assign cs[1] = gs[0] | (ps[0] & cs[0]);
        assign cs[2] = gs[1] | (ps[1] & gs[0]) | (ps[1] & ps[0] & cs[0]);
        assign cs[3] = gs[2] | (ps[2] & gs[1]) | (ps[2] & ps[1] & gs[0])
                     | (ps[2] & ps[1] & ps[0] & cs[0]);

        // Group generate/propagate give the slice carry-out without waiting on cs[3].
        assign grp_g = gs[3] | (ps[3] & gs[2]) | (ps[3] & ps[2] & gs[1])
                     | (ps[3] & ps[2] & ps[1] & gs[0]);
        assign grp_p = &ps;

        assign c[s+1]       = grp_g | (grp_p & c[s]);
        assign sum_o[4*s +: 4] = ps ^ cs;
    end

    assign cout_o = c[16];

endmodule

// File: rtl/mult_unit.sv
// Iterative shift-add 32x32->64 multiplier for MULT/MULTU with start/busy/done handshake.
// Optional `define MULT_EARLY_TERM_EN ends CALC once the remaining multiplier bits are zero.
module mult_unit
    import mult_pkg::*;
#(
    parameter int WIDTH = MULT_WIDTH,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int PW = 2 * WIDTH;

    state_e           state_q;
    logic [PW-1:0]    acc_q;
    logic [PW-1:0]    mcand_q;
    logic [WIDTH-1:0] mplier_q;
    logic [CNT_W-1:0] cnt_q;
    logic             neg_q;
    logic             fix_phase_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;

    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [WIDTH-1:0] mplier_d;
    logic             last_step;
    logic [PW-1:0]    add_a;
    logic [PW-1:0]    add_b;
    logic             add_cin;
    logic [PW-1:0]    add_sum;

    // Negating the most negative value wraps to itself, which is the correct magnitude as unsigned.
    assign mag_a    = (is_signed && op_a[WIDTH-1]) ? -op_a : op_a;
    assign mag_b    = (is_signed && op_b[WIDTH-1]) ? -op_b : op_b;
    assign mplier_d = mplier_q >> 1;

`ifdef MULT_EARLY_TERM_EN
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1)) || (mplier_d == '0);
`else
    assign last_step = (cnt_q == CNT_W'(WIDTH - 1));
`endif

    always_comb begin
        add_a   = acc_q;
        add_b   = mcand_q;
        add_cin = 1'b0;
        if (state_q == FIXUP) begin
            add_a   = ~acc_q;
            add_b   = '0;
            add_cin = 1'b1;
        end
    end

    add64_cla u_add (
        .a_i    (add_a),
        .b_i    (add_b),
        .cin_i  (add_cin),
        .sum_o  (add_sum),
        .cout_o ()
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            mcand_q     <= '0;
            mplier_q    <= '0;
            cnt_q       <= '0;
            neg_q       <= 1'b0;
            fix_phase_q <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            hi_q        <= '0;
            lo_q        <= '0;
        end else begin
            case (state_q)
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        mcand_q     <= {{WIDTH{1'b0}}, mag_a};
                        mplier_q    <= mag_b;
                        acc_q       <= '0;
                        cnt_q       <= '0;
                        neg_q       <= is_signed & (op_a[WIDTH-1] ^ op_b[WIDTH-1]);
                        fix_phase_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state_q     <= CALC;
                    end else begin
                        state_q <= IDLE;
                    end
                end
                CALC: begin
                    if (mplier_q[0]) begin
                        acc_q <= add_sum;
                    end
                    mcand_q  <= mcand_q << 1;
                    mplier_q <= mplier_d;
                    cnt_q    <= cnt_q + CNT_W'(1);
                    if (last_step) begin
                        fix_phase_q <= 1'b0;
                        state_q     <= FIXUP;
                    end
                end
                FIXUP: begin
                    // Two edges here: the first settles the signed result in acc,
                    // the second publishes it so hi/lo never see a pre-negation value.
                    if (!fix_phase_q) begin
                        if (neg_q) begin
                            acc_q <= add_sum;
                        end
                        fix_phase_q <= 1'b1;
                    end else begin
                        hi_q        <= acc_q[PW-1:WIDTH];
                        lo_q        <= acc_q[WIDTH-1:0];
                        done_q      <= 1'b1;
                        busy_q      <= 1'b0;
                        fix_phase_q <= 1'b0;
                        state_q     <= DONE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_mult_unit.sv
// Directed self-checking bench for mult_unit (MULT/MULTU, handshake, reset abort, early termination).
module tb_mult_unit;

    logic        clk;
    logic        rst;
    logic        start;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        done;
    logic [31:0] hi;
    logic [31:0] lo;

    int tests_run;
    int tests_failed;

    mult_unit #(.WIDTH(32), .CNT_W(6)) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .is_signed (is_signed),
        .op_a      (op_a),
        .op_b      (op_b),
        .busy      (busy),
        .done      (done),
        .hi        (hi),
        .lo        (lo)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Waits for done, sampling at falling edges; n = edges after the accepting edge, -1 on timeout.
    task automatic wait_done(input int limit, output int n);
        n = -1;
        for (int i = 1; i <= limit; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic s, output int n);
        op_a      = a;
        op_b      = b;
        is_signed = s;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        wait_done(200, n);
    endtask

    task automatic test_reset();
        rst   = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if ({busy, done} !== 2'b00) begin
            tests_failed++;
            $display("FAIL reset_flags busy/done=%b required 00", {busy, done});
        end
        tests_run++;
        if ({hi, lo} !== 64'h0) begin
            tests_failed++;
            $display("FAIL reset_hilo got %h required 0", {hi, lo});
        end
    endtask

    task automatic test_unsigned_max();
        int n;
        op_a      = 32'hFFFF_FFFF;
        op_b      = 32'hFFFF_FFFF;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL umax_busy got %b required 1", busy);
        end
        wait_done(200, n);
        tests_run++;
        if (n != 34) begin
            tests_failed++;
            $display("FAIL umax_latency got %0d required 34", n);
        end
        tests_run++;
        if (hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001) begin
            tests_failed++;
            $display("FAIL umax_result got %h_%h required fffffffe_00000001", hi, lo);
        end
        @(negedge clk);
        tests_run++;
        if (done !== 1'b0) begin
            tests_failed++;
            $display("FAIL umax_done_pulse got %b required 0", done);
        end
    endtask

    task automatic test_signed();
        int n;
        run_op(32'hFFFF_FFFD, 32'd5, 1'b1, n);
        tests_run++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFF1) begin
            tests_failed++;
            $display("FAIL signed_m3x5 got %h_%h required ffffffff_fffffff1 (n=%0d)", hi, lo, n);
        end
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, n);
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h1) begin
            tests_failed++;
            $display("FAIL signed_m1xm1 got %h_%h required 00000000_00000001", hi, lo);
        end
        run_op(32'h8000_0000, 32'd2, 1'b0, n);
        tests_run++;
        if (hi !== 32'h1 || lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL unsigned_2p31x2 got %h_%h required 00000001_00000000", hi, lo);
        end
    endtask

    task automatic test_signed_extremes();
        int n;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, n);
        tests_run++;
        if (hi !== 32'h4000_0000 || lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL smin_x_smin got %h_%h required 40000000_00000000", hi, lo);
        end
        run_op(32'h8000_0000, 32'd1, 1'b1, n);
        tests_run++;
        if (hi !== 32'hFFFF_FFFF || lo !== 32'h8000_0000) begin
            tests_failed++;
            $display("FAIL smin_x_1 got %h_%h required ffffffff_80000000", hi, lo);
        end
    endtask

    task automatic test_start_while_busy();
        int n;
        n         = -1;
        op_a      = 32'd3;
        op_b      = 32'd4;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i <= 200; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (done === 1'b1) begin
                n = i;
                break;
            end
            start = (i >= 5 && i <= 7);
            op_a  = 32'd9;
            op_b  = 32'd9;
        end
        start = 1'b0;
        tests_run++;
        if (n != 34) begin
            tests_failed++;
            $display("FAIL busy_ignore_latency got %0d required 34", n);
        end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'd12) begin
            tests_failed++;
            $display("FAIL busy_ignore_result got %h_%h required 00000000_0000000c", hi, lo);
        end
        repeat (3) @(negedge clk);
        tests_run++;
        if (lo !== 32'd12 || done !== 1'b0) begin
            tests_failed++;
            $display("FAIL result_hold got lo=%h done=%b required lo=0000000c done=0", lo, done);
        end
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(32'd100, 32'd100, 1'b0, n);
        op_a      = 32'd7;
        op_b      = 32'd6;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        tests_run++;
        if (busy !== 1'b1 || lo !== 32'd10000) begin
            tests_failed++;
            $display("FAIL b2b_accept got busy=%b lo=%h required busy=1 lo=00002710", busy, lo);
        end
        wait_done(200, n);
        tests_run++;
        if (n != 34) begin
            tests_failed++;
            $display("FAIL b2b_latency got %0d required 34", n);
        end
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'h2A) begin
            tests_failed++;
            $display("FAIL b2b_result got %h_%h required 00000000_0000002a", hi, lo);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        int seen;
        seen      = 0;
        op_a      = 32'h1234;
        op_b      = 32'h5678;
        is_signed = 1'b0;
        start     = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        tests_run++;
        if (busy !== 1'b0 || done !== 1'b0 || hi !== 32'h0 || lo !== 32'h0) begin
            tests_failed++;
            $display("FAIL midrst_state got busy=%b done=%b hi=%h lo=%h required all 0", busy, done, hi, lo);
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (done === 1'b1) seen++;
        end
        tests_run++;
        if (seen != 0) begin
            tests_failed++;
            $display("FAIL midrst_no_done got %0d pulses required 0", seen);
        end
        run_op(32'd2, 32'd3, 1'b0, n);
        tests_run++;
        if (hi !== 32'h0 || lo !== 32'd6 || n < 0) begin
            tests_failed++;
            $display("FAIL midrst_recover got %h_%h n=%0d required 00000000_00000006", hi, lo, n);
        end
    endtask

    task automatic test_mixed_product();
        int n;
        logic [63:0] expv;
        expv = 64'h1234_5678 * 64'h9ABC_DEF0;
        run_op(32'h1234_5678, 32'h9ABC_DEF0, 1'b0, n);
        tests_run++;
        if ({hi, lo} !== expv) begin
            tests_failed++;
            $display("FAIL mixed_product got %h required %h", {hi, lo}, expv);
        end
    endtask

`ifdef MULT_EARLY_TERM_EN
    task automatic test_early_term();
        int n;
        run_op(32'd7, 32'd3, 1'b0, n);
        tests_run++;
        if (n != 4 || lo !== 32'd21 || hi !== 32'h0) begin
            tests_failed++;
            $display("FAIL early_7x3 got n=%0d %h_%h required n=4 00000000_00000015", n, hi, lo);
        end
        run_op(32'd5, 32'd0, 1'b0, n);
        tests_run++;
        if (n != 3 || lo !== 32'h0 || hi !== 32'h0) begin
            tests_failed++;
            $display("FAIL early_5x0 got n=%0d %h_%h required n=3 0", n, hi, lo);
        end
    endtask
`endif

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        start        = 1'b0;
        is_signed    = 1'b0;
        op_a         = '0;
        op_b         = '0;
        @(negedge clk);
        test_reset();
        test_unsigned_max();
        test_signed();
        test_signed_extremes();
        test_start_while_busy();
        test_back_to_back();
        test_mid_reset();
        test_mixed_product();
`ifdef MULT_EARLY_TERM_EN
        test_early_term();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
